// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file, two async read ports, one write port, clear sequencer
// Optional write-through forwarding: define REGFILE_BYPASS_EN.
module regfile_param #(
    parameter int                 WIDTH    = 8,
    parameter int                 ADDR_W   = 2,
    parameter int                 ZERO_REG = 0,
    parameter logic [WIDTH-1:0]   CLR_VAL  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] dr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] sr1,
    input  logic [ADDR_W-1:0] sr2,
    output logic [WIDTH-1:0]  rd_data1,
    output logic [WIDTH-1:0]  rd_data2,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic               wr_ready_q, wr_ready_d;
    logic               clr_busy_q, clr_busy_d;
    logic               clr_done_q, clr_done_d;
    logic               wr_fire;

    assign wr_fire = wr_en & wr_ready_q;

    // Outputs are registered from the next-state decode so they line up with state_q.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE: begin
                if (wr_fire && !(ZERO_REG != 0 && dr == '0)) begin
                    mem_d[dr] = wr_data;
                end
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                mem_d[idx_q] = CLR_VAL;
                if (&idx_q) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        wr_ready_d = (state_d == IDLE);
        clr_busy_d = (state_d == CLEAR);
        clr_done_d = (state_d == CLEAR) && (&idx_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wr_ready_q <= 1'b1;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= CLR_VAL;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_ready_q <= wr_ready_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
            mem_q      <= mem_d;
        end
    end

    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] sr);
        logic [WIDTH-1:0] val;
`ifdef REGFILE_BYPASS_EN
        if (wr_fire && sr == dr) begin
            val = wr_data;
        end else if (state_q == CLEAR && sr == idx_q) begin
            val = CLR_VAL;
        end else begin
            val = mem_q[sr];
        end
`else
        val = mem_q[sr];
`endif
        if (ZERO_REG != 0 && sr == '0) begin
            val = '0;
        end
        return val;
    endfunction

    assign rd_data1 = read_port(sr1);
    assign rd_data2 = read_port(sr2);
    assign wr_ready = wr_ready_q;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - randomized bench for regfile_param against a behavioural model
module tb_regfile_param;

    logic       clk = 1'b0;
    logic       reset, wr_en, clr_req;
    logic [1:0] dr, sr1, sr2;
    logic [7:0] wr_data;
    logic [7:0] rd1 [2];
    logic [7:0] rd2 [2];
    logic       ready [2];
    logic       busy [2];
    logic       done [2];

    int n_cmp = 0;
    int n_err = 0;

    // model: per-instance contents, clear position (-1 when idle)
    logic [7:0] m [2][4];
    logic [7:0] clrv [2];
    int         cidx;

    always #5 clk = ~clk;

    regfile_param #(.WIDTH(8), .ADDR_W(2), .ZERO_REG(0), .CLR_VAL(8'h00)) u_plain (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ready(ready[0]), .dr(dr),
        .wr_data(wr_data), .sr1(sr1), .sr2(sr2), .rd_data1(rd1[0]), .rd_data2(rd2[0]),
        .clr_req(clr_req), .clr_busy(busy[0]), .clr_done(done[0])
    );

    regfile_param #(.WIDTH(8), .ADDR_W(2), .ZERO_REG(1), .CLR_VAL(8'hE7)) u_zero (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ready(ready[1]), .dr(dr),
        .wr_data(wr_data), .sr1(sr1), .sr2(sr2), .rd_data1(rd1[1]), .rd_data2(rd2[1]),
        .clr_req(clr_req), .clr_busy(busy[1]), .clr_done(done[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_rd(input int inst, input logic [1:0] sr);
        if (inst == 1 && sr == 2'd0) return 8'h00;
`ifdef REGFILE_BYPASS_EN
        if (cidx < 0 && wr_en && sr == dr) return wr_data;
        if (cidx >= 0 && int'(sr) == cidx) return clrv[inst];
`endif
        return m[inst][sr];
    endfunction

    task automatic compare_all();
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("rd_data1[%0d]", j), {24'd0, rd1[j]}, {24'd0, exp_rd(j, sr1)});
            chk($sformatf("rd_data2[%0d]", j), {24'd0, rd2[j]}, {24'd0, exp_rd(j, sr2)});
            chk($sformatf("wr_ready[%0d]", j), {31'd0, ready[j]}, {31'd0, cidx < 0});
            chk($sformatf("clr_busy[%0d]", j), {31'd0, busy[j]}, {31'd0, cidx >= 0});
            chk($sformatf("clr_done[%0d]", j), {31'd0, done[j]}, {31'd0, cidx == 3});
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            for (int j = 0; j < 2; j++)
                for (int i = 0; i < 4; i++) m[j][i] = clrv[j];
            cidx = -1;
        end else if (cidx >= 0) begin
            for (int j = 0; j < 2; j++) m[j][cidx] = clrv[j];
            cidx = (cidx == 3) ? -1 : cidx + 1;
        end else begin
            if (wr_en)
                for (int j = 0; j < 2; j++) m[j][dr] = wr_data;
            if (clr_req) cidx = 0;
        end
    endtask

    // compare mid-cycle, advance model at the edge, then return just after it
    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1; dr = a; wr_data = d;
        cycle();
        wr_en = 1'b0;
    endtask

    initial begin
        clrv[0] = 8'h00;
        clrv[1] = 8'hE7;
        cidx = -1;
        reset = 1'b1; wr_en = 1'b0; clr_req = 1'b0;
        dr = 2'd0; sr1 = 2'd0; sr2 = 2'd0; wr_data = 8'h00;
        @(posedge clk);
        model_edge();
        #1;
        cycle();
        reset = 1'b0;
        #1;
        chk("reset wr_ready", {31'd0, ready[0]}, 32'd1);
        chk("reset clr_busy", {31'd0, busy[0]}, 32'd0);
        chk("reset clr_val", {24'd0, rd1[1]}, 32'h00);

        // fill, then flat reset
        wr(2'd0, 8'hAA); wr(2'd1, 8'hBB); wr(2'd2, 8'hCC); wr(2'd3, 8'hDD);
        sr1 = 2'd3; #1;
        chk("fill entry3", {24'd0, rd1[0]}, 32'hDD);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sr1 = 2'(i); sr2 = 2'(i); #1;
            chk("flat clear", {24'd0, rd1[0]}, 32'h00);
        end
        sr2 = 2'd1; #1;
        chk("flat clear CLR_VAL", {24'd0, rd2[1]}, 32'hE7);

        // write/read, both ports on one entry
        wr(2'd2, 8'h5A);
        sr1 = 2'd2; sr2 = 2'd2; #1;
        chk("wr/rd port1", {24'd0, rd1[0]}, 32'h5A);
        chk("wr/rd port2", {24'd0, rd2[0]}, 32'h5A);

        // hardwired zero entry
        wr_en = 1'b1; dr = 2'd0; wr_data = 8'hFF; #1;
        chk("zero wr acked", {31'd0, ready[1]}, 32'd1);
        cycle();
        wr_en = 1'b0;
        wr(2'd1, 8'h11);
        sr1 = 2'd0; sr2 = 2'd1; #1;
        chk("zero reads 0", {24'd0, rd1[1]}, 32'h00);
        chk("plain entry0", {24'd0, rd1[0]}, 32'hFF);
        chk("zero entry1", {24'd0, rd2[1]}, 32'h11);

        // clear sequence with a write held across it
        for (int i = 0; i < 4; i++) wr(2'(i), 8'h77);
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wr_en = 1'b1; dr = 2'd1; wr_data = 8'h99;
            sr1 = 2'((k == 0) ? 0 : k - 1); sr2 = 2'(k); #1;
            chk("clear busy", {31'd0, busy[0]}, 32'd1);
            chk("clear ready", {31'd0, ready[0]}, 32'd0);
            chk("clear done", {31'd0, done[0]}, {31'd0, k == 3});
            if (k > 0) chk("cleared entry", {24'd0, rd1[0]}, 32'h00);
`ifdef REGFILE_BYPASS_EN
            chk("clearing entry", {24'd0, rd2[0]}, 32'h00);
`else
            chk("clearing entry", {24'd0, rd2[0]}, 32'h77);
`endif
            cycle();
        end
        #1;
        chk("post clear ready", {31'd0, ready[0]}, 32'd1);
        chk("post clear busy", {31'd0, busy[0]}, 32'd0);
        cycle();
        wr_en = 1'b0; sr1 = 2'd1; sr2 = 2'd3; #1;
        chk("held write", {24'd0, rd1[0]}, 32'h99);
        chk("cleared entry3", {24'd0, rd2[0]}, 32'h00);

        // write and clear in the same cycle
        wr(2'd3, 8'h55);
        wr_en = 1'b1; dr = 2'd3; wr_data = 8'h42; clr_req = 1'b1;
        cycle();
        wr_en = 1'b0; clr_req = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        sr1 = 2'd3; #1;
        chk("wr+clr entry3", {24'd0, rd1[0]}, 32'h00);

        // reset on the second clear cycle
        for (int i = 0; i < 4; i++) wr(2'(i), 8'h66);
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        cycle();
        reset = 1'b1; #1;
        chk("abort busy before", {31'd0, busy[0]}, 32'd1);
        cycle();
        reset = 1'b0; #1;
        chk("abort ready", {31'd0, ready[0]}, 32'd1);
        chk("abort no done", {31'd0, done[0]}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            sr1 = 2'(i); #1;
            chk("abort entries", {24'd0, rd1[0]}, 32'h00);
        end
        cycle();

        // same-cycle visibility
        wr_en = 1'b1; dr = 2'd1; wr_data = 8'h3C; sr2 = 2'd1; #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass same cycle", {24'd0, rd2[0]}, 32'h3C);
`else
        chk("no bypass same cycle", {24'd0, rd2[0]}, 32'h00);
`endif
        cycle();
        wr_en = 1'b0;

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            reset   = ($urandom_range(0, 99) == 0);
            clr_req = ($urandom_range(0, 19) == 0);
            wr_en   = 1'($urandom_range(0, 1));
            dr      = 2'($urandom_range(0, 3));
            sr1     = 2'($urandom_range(0, 3));
            sr2     = 2'($urandom_range(0, 3));
            wr_data = 8'($urandom_range(0, 255));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the team's 4x8 register bank: configurable data width and depth, two asynchronous read ports, one write port with a ready handshake.
- Adds an optional hardwired-zero entry 0 and a hardware clear sequencer that wipes the array one entry per cycle on request.
- Sits between the datapath ALU (reads sr1/sr2) and the control unit (issues write and clear).

Parameters:
WIDTH, 8, data width of each entry in bits
ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries (default 4)
ZERO_REG, 0, if 1 entry 0 always reads 0 and writes to it are discarded (still acknowledged)
CLR_VAL, 0, WIDTH-bit value loaded into each entry by reset and by the clear sequencer

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  write request
wr_ready  out  1  write accepted this cycle when wr_en & wr_ready
dr  in  ADDR_W  write address
wr_data  in  WIDTH  write data
sr1  in  ADDR_W  read address, port 1
sr2  in  ADDR_W  read address, port 2
rd_data1  out  WIDTH  read data, port 1
rd_data2  out  WIDTH  read data, port 2
clr_req  in  1  single-cycle pulse starting the clear sequence
clr_busy  out  1  clear sequence in progress
clr_done  out  1  one-cycle pulse on the final clear cycle

Behaviour:
- Reset: reset is synchronous, active-high on clk. On a reset cycle every entry loads CLR_VAL in that one cycle. FSM goes to IDLE, clear index goes to 0, clr_busy=0, clr_done=0, wr_ready=1.
- Reset has priority over everything, including a clear in progress. Reset mid-clear aborts the sequence and issues no clr_done.
- Read: combinational. rd_dataN = array[srN], or 0 when ZERO_REG=1 and srN==0. Both ports may address the same entry.
- Write: when wr_en & wr_ready, array[dr] <= wr_data at the rising edge. The new value is visible on reads from the next cycle, unless REGFILE_BYPASS_EN is defined.
- wr_ready = (state==IDLE). wr_en while wr_ready=0 is ignored. The requester must hold the request until it is accepted.
- FSM IDLE:
  - clr_req=1 -> CLEAR, index <= 0.
  - If wr_en and clr_req arrive in the same cycle, the write is accepted first (wr_ready is still 1), then the clear starts next cycle. The written entry is therefore cleared.
- FSM CLEAR:
  - Each cycle: array[index] <= CLR_VAL and clr_busy=1.
  - If index != DEPTH-1: index <= index+1.
  - If index == DEPTH-1: clr_done=1 that cycle, next state IDLE, index wraps to 0.
  - The sequence takes exactly DEPTH cycles. clr_busy falls and wr_ready rises on the cycle after clr_done.
- clr_req during CLEAR is ignored; it does not restart the sequence.
- Reads during CLEAR return the current array contents: entries already cleared show CLR_VAL, others keep their old value.
- Entry 0 with ZERO_REG=1: storage may be omitted; reads are always 0 regardless of CLR_VAL.
- Out-of-range addresses are impossible, since DEPTH = 2**ADDR_W.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If wr_en & wr_ready and srN==dr, rd_dataN = wr_data in the same cycle.
  - ZERO_REG masking still wins for address 0.
  - During CLEAR, srN==index returns CLR_VAL in the same cycle.
- Undefined: reads reflect stored contents only; a written value appears one cycle after the accepting edge.

Test Plan:
- Reset flat clear: write 0xAA,0xBB,0xCC,0xDD to entries 0..3, assert reset one cycle -> all four read 0x00 next cycle, wr_ready=1, clr_busy=0.
- Write/read: write 0x5A to dr=2 -> rd_data1 (sr1=2) = 0x5A the cycle after acceptance. Also check sr1=sr2=2 gives 0x5A on both ports.
- ZERO_REG=1: write 0xFF to dr=0 -> wr_ready=1 (accepted), rd_data1 (sr1=0) stays 0x00. Entry 1 written with 0x11 reads 0x11.
- Clear sequence, DEPTH=4, all entries 0x77:
  - pulse clr_req -> clr_busy high for 4 cycles, clr_done on the 4th.
  - Entries read 0x00 progressively in order 0..3.
  - wr_en=1 with dr=1, data 0x99 held through the clear is accepted only on the first IDLE cycle; entry 1 = 0x99 afterwards.
- Simultaneous and abort cases:
  - wr_en (dr=3, 0x42) plus clr_req in the same IDLE cycle -> entry 3 ends at 0x00.
  - Reset asserted on the 2nd CLEAR cycle -> FSM IDLE next cycle, no clr_done, all entries CLR_VAL.
- REGFILE_BYPASS_EN defined: write 0x3C to dr=1 with sr2=1 -> rd_data2=0x3C in the same cycle as wr_en. Undefined: rd_data2 shows the old value that cycle.
